// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory.
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {CLEAR, READY} state_e;

  // Per-request control carried alongside the read word through the pipeline
  typedef struct packed {
    logic       we;
    logic       err;
    logic       uns;
    logic [1:0] size;
    logic [1:0] lane;
  } ctl_t;

  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    be_of = 4'b0001 << lane;
      SZ_H:    be_of = 4'b0011 << lane;
      SZ_W:    be_of = 4'b1111;
      default: be_of = 4'b0000;
    endcase
  endfunction

  // Misaligned half/word or the reserved size encoding
  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] lane);
    is_bad = (size == 2'b11) ||
             ((size == SZ_H) && lane[0]) ||
             ((size == SZ_W) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: replicate store data across lanes, extract and
// extend load data from the addressed lane.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [31:0] wdata_i,
  input  logic [1:0]  wsize_i,
  output logic [31:0] wrep_o,
  input  logic [31:0] rword_i,
  input  logic [1:0]  rsize_i,
  input  logic [1:0]  rlane_i,
  input  logic        runs_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Store side: copy the low-aligned datum into every lane it could land in
  always_comb begin
    case (wsize_i)
      SZ_B:    wrep_o = {4{wdata_i[7:0]}};
      SZ_H:    wrep_o = {2{wdata_i[15:0]}};
      default: wrep_o = wdata_i;
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend
  always_comb begin
    shifted = rword_i >> {rlane_i, 3'b000};
    case (rsize_i)
      SZ_B:    rdata_o = runs_i ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    rdata_o = runs_i ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata_o = rword_i;
    endcase
  end

endmodule

// File: rtl/dm_pipe_mem.sv
// MEM-stage data memory: sized loads/stores with byte-lane merge,
// fixed-latency in-order responses and a post-reset clearing sweep.
module dm_pipe_mem
  import dm_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1,
  parameter bit TRACE    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LAST  = READ_LAT - 1;

  logic [31:0]       mem_q [DEPTH];
  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              ready_q;
  logic              done_q;

  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              acc;
  logic              bad;
  logic              commit;
  logic [3:0]        be;
  logic [31:0]       wrep;
  logic [31:0]       ld_data;

  logic [READ_LAT-1:0] vld_p;
  ctl_t                ctl_p  [READ_LAT];
  logic [31:0]         word_p [READ_LAT];

  assign idx    = req_addr[ADDR_W+1:2];
  assign lane   = req_addr[1:0];
  assign acc    = req_valid && ready_q;
  assign bad    = is_bad(req_size, lane);
  assign commit = acc && req_we && !bad;
  assign be     = be_of(req_size, lane);

  assign req_ready = ready_q;
  assign init_done = done_q;

  // Clear sweep, then accept requests forever; outputs registered with the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (&clr_cnt_q) begin
            state_q <= READY;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array writes: sweep zeros while clearing, byte-enabled stores afterwards
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wrep[8*b +: 8];
      end
    end
  end

  // Stage boundary p0..pLAST: response valid bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= acc;
      for (int i = 1; i < READ_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Stage boundary p0..pLAST: array word and request control
  always_ff @(posedge clk) begin
    if (acc) begin
      word_p[0]     <= mem_q[idx];
      ctl_p[0].we   <= req_we;
      ctl_p[0].err  <= bad;
      ctl_p[0].uns  <= req_unsigned;
      ctl_p[0].size <= req_size;
      ctl_p[0].lane <= lane;
    end
    for (int i = 1; i < READ_LAT; i++) begin
      word_p[i] <= word_p[i-1];
      ctl_p[i]  <= ctl_p[i-1];
    end
  end

  dm_lane_align u_align (
    .wdata_i (req_wdata),
    .wsize_i (req_size),
    .wrep_o  (wrep),
    .rword_i (word_p[LAST]),
    .rsize_i (ctl_p[LAST].size),
    .rlane_i (ctl_p[LAST].lane),
    .runs_i  (ctl_p[LAST].uns),
    .rdata_o (ld_data)
  );

  assign rsp_valid = vld_p[LAST];
  assign rsp_err   = vld_p[LAST] && ctl_p[LAST].err;
  assign rsp_rdata = (vld_p[LAST] && !ctl_p[LAST].we && !ctl_p[LAST].err) ? ld_data : '0;

  generate
    if (TRACE) begin : g_trace
      logic [31:0] merged;

      // Post-merge word as it will appear in the array after this edge
      always_comb begin
        merged = mem_q[idx];
        for (int b = 0; b < 4; b++) begin
          if (be[b]) merged[8*b +: 8] = wrep[8*b +: 8];
        end
      end

      // One line per committed store
      always_ff @(posedge clk) begin
        if (commit) $write("%d@%h: *%h <= %h\n", $time, req_pc, {idx, 2'b00}, merged);
      end
    end
  endgenerate

endmodule
